axi_sram_slave: RTL and testbench

AXI3 slave memory model that answers the CPU-side AXI master: the instruction-cache refill bursts, the data reads and the single-beat stores. It sits at the far end of the bus from the core top and backs a word-addressed register array. The read and write channels run independent state machines, with at most one outstanding transaction per direction. The block serves both as the functional-simulation memory and as the verification target for the bridge's burst handling.

---
 rtl/axi_sram_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
// axi_sram_slave
// AXI3 slave memory model backing a word-addressed array. Serves instruction
// refill bursts, data reads and single-beat stores from the CPU-side master.
// Read and write channels run independent FSMs, one outstanding transaction
// per direction, INCR bursts only, every response OKAY.
//
// Parameters:
//   MEM_WORDS  array depth in 32-bit words (power of two)
//   RD_LAT     wait cycles between AR handshake and first rvalid (0 allowed)
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   arid/araddr/arlen/arsize/arvalid  read request in, arready out
//   rid/rdata/rlast/rvalid            read beat out, rready in
//   awid/awaddr/awlen/awsize/awvalid  write request in, awready out
//   wdata/wstrb/wvalid                write data in, wready out
//   bid/bvalid                        write response out, bready in
module axi_sram_slave #(
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic             en_reg;

  logic [1:0]       r_state_reg;
  logic [3:0]       rid_reg;
  logic [31:0]      rd_addr_reg;
  logic [7:0]       rd_len_reg;
  logic [7:0]       rd_beat_reg;
  logic [2:0]       rd_size_reg;
  logic [7:0]       rd_wait_reg;

  logic [1:0]       w_state_reg;
  logic [3:0]       bid_reg;
  logic [31:0]      wr_addr_reg;
  logic [7:0]       wr_len_reg;
  logic [7:0]       wr_beat_reg;
  logic [2:0]       wr_size_reg;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_fire;

  // Upper address bits alias; byte offset is ignored for indexing.
  assign rd_idx  = rd_addr_reg[IDX_W+1:2];
  assign wr_idx  = wr_addr_reg[IDX_W+1:2];

  assign arready = en_reg && (r_state_reg == R_IDLE);
  assign rvalid  = (r_state_reg == R_DATA);
  assign rlast   = (r_state_reg == R_DATA) && (rd_beat_reg == rd_len_reg);
  assign rid     = rid_reg;

  assign awready = en_reg && (w_state_reg == W_IDLE);
  assign wready  = (w_state_reg == W_DATA);
  assign bvalid  = (w_state_reg == W_RESP);
  assign bid     = bid_reg;
  assign wr_fire = wready && wvalid;

  // Handshakes are held off for one cycle after reset release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) en_reg <= 1'b0;
    else        en_reg <= 1'b1;
  end

  // Read channel
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_reg <= R_IDLE;
      rid_reg     <= 4'd0;
      rd_addr_reg <= 32'd0;
      rd_len_reg  <= 8'd0;
      rd_beat_reg <= 8'd0;
      rd_size_reg <= 3'd0;
      rd_wait_reg <= 8'd0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid && arready) begin
            rid_reg     <= arid;
            rd_addr_reg <= araddr;
            rd_len_reg  <= arlen;
            rd_size_reg <= arsize;
            rd_beat_reg <= 8'd0;
            rd_wait_reg <= 8'd0;
            r_state_reg <= (RD_LAT == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          rd_wait_reg <= rd_wait_reg + 8'd1;
          if (rd_wait_reg == 8'(RD_LAT - 1)) r_state_reg <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rd_addr_reg <= rd_addr_reg + (32'd1 << rd_size_reg);
            rd_beat_reg <= rd_beat_reg + 8'd1;
            if (rlast) r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // Write channel
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_reg <= W_IDLE;
      bid_reg     <= 4'd0;
      wr_addr_reg <= 32'd0;
      wr_len_reg  <= 8'd0;
      wr_beat_reg <= 8'd0;
      wr_size_reg <= 3'd0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awvalid && awready) begin
            bid_reg     <= awid;
            wr_addr_reg <= awaddr;
            wr_len_reg  <= awlen;
            wr_size_reg <= awsize;
            wr_beat_reg <= 8'd0;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            wr_addr_reg <= wr_addr_reg + (32'd1 << wr_size_reg);
            wr_beat_reg <= wr_beat_reg + 8'd1;
            if (wr_beat_reg == wr_len_reg) w_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) w_state_reg <= W_IDLE;
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // One byte-wide array per lane keeps strobed writes simple. Reads are
  // combinational so a write committed at an edge is visible the next cycle,
  // while a same-cycle read of the word being written still returns old data.
  // The array is deliberately outside the reset domain: contents survive reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];

      always_ff @(posedge aclk) begin
        if (wr_fire && wstrb[gi]) lane_mem[wr_idx] <= wdata[8*gi +: 8];
      end

      assign rdata[8*gi +: 8] = lane_mem[rd_idx];
    end
  endgenerate

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
// Self-checking bench for axi_sram_slave: directed scenarios followed by
// randomized bursts, compared against a word-indexed associative-array model.
module tb_axi_sram_slave;

  localparam int MEM_WORDS = 4096;
  localparam int RD_LAT    = 2;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_sram_slave #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory: word index -> contents. Only written words exist.
  logic [31:0] mem_model [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(MEM_WORDS - 1));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int i = widx(a);
    if (mem_model.exists(i)) return mem_model[i];
    return 'x;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i = widx(a);
    logic [31:0] w = mem_model.exists(i) ? mem_model[i] : 32'h0;
    for (int l = 0; l < 4; l++) if (s[l]) w[8*l +: 8] = d[8*l +: 8];
    mem_model[i] = w;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [31:0] data0,
                          input logic [3:0] strb0, input bit rnd);
    int n;
    logic [31:0] d;
    logic [3:0]  s;
    $display("wr id=%0d addr=%h len=%0d size=%0d rnd=%0d", id, addr, len, size, rnd);
    check("w_idle_wready", wready, 0);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge aclk); n++; end
    check("aw_hs", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge aclk);
      d = rnd ? 32'($urandom) : data0 + 32'(b);
      s = rnd ? 4'($urandom_range(0, 15)) : strb0;
      wvalid = 1'b1; wdata = d; wstrb = s;
      n = 0;
      while (!wready && n < 100) begin @(negedge aclk); n++; end
      check("w_hs", wready, 1);
      model_wr(addr + (32'(b) << size), d, s);
      @(negedge aclk);
      wvalid = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 100) begin @(negedge aclk); n++; end
    check("bvalid", bvalid, 1);
    check("bid", bid, 32'(id));
    check("aw_busy", awready, 0);
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge aclk);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("b_done", bvalid, 0);
    check("aw_free", awready, 1);
  endtask

  // mode 0: rready held high, 1: pattern 1,0,0,1, 2: random
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input int mode);
    logic [31:0] exp_q[$];
    int n, b, k;
    for (int i = 0; i <= len; i++) exp_q.push_back(model_rd(addr + (32'(i) << size)));
    $display("rd id=%0d addr=%h len=%0d size=%0d mode=%0d", id, addr, len, size, mode);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    check("ar_hs", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("ar_busy", arready, 0);
    n = 1;
    while (!rvalid && n < 100) begin @(negedge aclk); n++; end
    check("rd_latency", 32'(n), 32'(RD_LAT + 1));
    b = 0; k = 0;
    while (b <= len && k < 1000) begin
      if (!rvalid) begin
        check("rvalid_gap", rvalid, 1);
        break;
      end
      check("rdata", rdata, exp_q[b]);
      check("rlast", rlast, 32'(b == len));
      check("rid", rid, 32'(id));
      check("ar_busy_beat", arready, 0);
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (k % 4 == 0) || (k % 4 == 3);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rready) b++;
      k++;
      @(negedge aclk);
    end
    rready = 1'b0;
    check("r_done_rvalid", rvalid, 0);
    check("r_done_arready", arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, len, mode;
    logic [2:0]  size;
    logic [31:0] addr;

    // Reset release
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    @(negedge aclk);
    check("en_arready", arready, 1);
    check("en_awready", awready, 1);

    // Single write then read, plus an aliased read of the same word
    do_write(4'd1, 32'h1C00_0010, 0, 3'd2, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_read(4'd0, 32'h1C00_0010, 0, 3'd2, 0);
    do_read(4'd5, 32'h0000_0010, 0, 3'd2, 0);

    // Refill burst and the same burst under backpressure
    do_write(4'd2, 32'h0000_0040, 3, 3'd2, 32'd1, 4'hF, 1'b0);
    do_read(4'd0, 32'h0000_0040, 3, 3'd2, 0);
    do_read(4'd0, 32'h0000_0040, 3, 3'd2, 1);

    // Byte strobes: expect 0x11BB33DD
    do_write(4'd3, 32'h0000_0080, 0, 3'd2, 32'h1122_3344, 4'hF, 1'b0);
    do_write(4'd3, 32'h0000_0080, 0, 3'd2, 32'hAABB_CCDD, 4'h5, 1'b0);
    do_read(4'd1, 32'h0000_0080, 0, 3'd2, 0);
    check("strobe_model", model_rd(32'h80), 32'h11BB_33DD);

    // Burst wrapping past the top of the 32-bit space into word 0
    do_write(4'd6, 32'hFFFF_FFF8, 3, 3'd2, 32'hC0DE_0000, 4'hF, 1'b0);
    do_read(4'd7, 32'hFFFF_FFF8, 3, 3'd2, 2);

    // Reset mid-burst: assert during beat 2 of 4
    $display("rd id=2 addr=00000040 len=3 aborted by reset");
    arid = 4'd2; araddr = 32'h40; arlen = 8'd3; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    check("rst_ar_hs", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    rready  = 1'b1;
    n = 0;
    while (!rvalid && n < 100) begin @(negedge aclk); n++; end
    check("rst_beat1", rdata, 32'd1);
    @(negedge aclk);
    check("rst_beat2", rdata, 32'd2);
    #2 areset = 1'b1;
    #1;
    check("abort_rvalid", rvalid, 0);
    check("abort_rlast", rlast, 0);
    check("abort_arready", arready, 0);
    @(negedge aclk);
    rready = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rel_arready", arready, 0);
    check("rel_awready", awready, 0);
    check("rel_rid", rid, 0);
    check("rel_rdata_word0", rdata, model_rd(32'h0));
    @(negedge aclk);
    check("rel_en_arready", arready, 1);
    do_read(4'd0, 32'h0000_0040, 3, 3'd2, 0);

    // Window 0x400..0x4FF preloaded with full strobes for random traffic
    do_write(4'd4, 32'h0000_0400, 63, 3'd2, 32'h0000_1000, 4'hF, 1'b0);

    // Concurrent read and write on disjoint regions
    fork
      do_write(4'd9, 32'h0000_0800, 5, 3'd2, 32'($urandom), 4'hF, 1'b0);
      do_read(4'd8, 32'h0000_0410, 7, 3'd2, 2);
    join
    do_read(4'd8, 32'h0000_0800, 5, 3'd2, 0);

    // Randomized traffic inside the window, with aliased upper address bits
    for (int t = 0; t < 30; t++) begin
      len  = $urandom_range(0, 7);
      size = 3'($urandom_range(0, 2));
      addr = 32'h400 + 32'($urandom_range(0, 55)) * 4 + 32'($urandom_range(0, 3));
      addr = addr + (32'($urandom) & 32'hFFFF_C000);
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        do_write(4'($urandom), addr, len, size, 32'h0, 4'h0, 1'b1);
      else
        do_read(4'($urandom), addr, len, size, mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
